// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO, programmable bit divisor, level IRQ.
// Optional even-parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        tx
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DEPTH_CNT = 5'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state, state_next;
  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]  count;
  logic        ovf, en, ie, irq;
  logic [15:0] div, div_lat, baud_cnt;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        full, empty, busy, push, load, shift_en, bit_done, tx_next;
  logic        wr_data, wr_status, wr_div, wr_ctrl;
`ifdef UART_TX_PARITY_EN
  logic        parity;
`endif

  logic unused;
  assign unused = ^{Addr[31:4], Din[31:16]};

  assign wr_data   = WE && (Addr[3:2] == 2'd0);
  assign wr_status = WE && (Addr[3:2] == 2'd1);
  assign wr_div    = WE && (Addr[3:2] == 2'd2);
  assign wr_ctrl   = WE && (Addr[3:2] == 2'd3);

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign push     = wr_data && !full;
  assign bit_done = (baud_cnt == div_lat);
  assign IRQ      = irq;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= Din[7:0];
  end

  // Push is gated by the pre-edge FULL, so a pop on the same edge never makes room for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= DEFAULT_DIV;
      en  <= 1'b0;
      ie  <= 1'b0;
      ovf <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_div) div <= Din[15:0];
      if (wr_ctrl) begin
        en <= Din[0];
        ie <= Din[1];
      end
      if (wr_data && full) ovf <= 1'b1;
      else if (wr_status && Din[4]) ovf <= 1'b0;
      irq <= ie & empty & ~busy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_next    = tx;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (en && !empty) begin
          state_next = START;
          load       = 1'b1;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          tx_next    = shift[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = parity;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            shift_en = 1'b1;
            tx_next  = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (en && !empty) begin
            state_next = START;
            load       = 1'b1;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // Divisor is captured at frame start so DIV writes only affect later frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      div_lat  <= DEFAULT_DIV;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      tx <= tx_next;
      if (load) begin
        shift    <= mem[rd_ptr];
        div_lat  <= div;
        baud_cnt <= '0;
        bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
        parity   <= ^mem[rd_ptr];
`endif
      end else begin
        if (state == IDLE || bit_done) baud_cnt <= '0;
        else                           baud_cnt <= baud_cnt + 16'd1;
        if (shift_en) begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      2'd1:    Dout = {22'b0, count, ovf, busy, irq, full, empty};
      2'd2:    Dout = {16'b0, div};
      2'd3:    Dout = {30'b0, ie, en};
      default: Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: register checks plus a serial-line monitor that decodes frames
// against a queue of expected bytes and the divisor in force at frame start.
module tb_uart_tx;

  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:2] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ, tx;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];
  int model_div = 433;
  int idle_run  = 0;
  int last_gap  = -1;
  logic [31:0] st, rd;

  always #5 clk = ~clk;

  uart_tx #(.DEPTH(DEPTH), .DEFAULT_DIV(16'd433)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .IRQ(IRQ), .tx(tx)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // All bus tasks start just after a falling edge and end at the next one.
  task automatic bus_write(input int a, input logic [31:0] d);
    Addr = 30'(a);
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    Addr = 30'(a);
    WE   = 1'b0;
    #1;
    d = Dout;
    @(negedge clk);
  endtask

  task automatic set_div(input int d);
    bus_write(2, 32'(d));
    model_div = d;
  endtask

  task automatic wait_idle(input string name, input int limit);
    logic [31:0] s;
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      bus_read(1, s);
      if (s[3] == 1'b0 && s[0] == 1'b1) done = 1'b1;
    end
    check({name, "_idle"}, 32'(done), 32'd1);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Line monitor: every bit must hold its value for exactly model_div+1 samples.
  initial begin : monitor
    logic [7:0]  cur;
    logic [10:0] bits;
    int period;
    bit aborted, bad;
    logic got;
    forever begin
      @(negedge clk);
      if (rst) idle_run = 0;
      else if (tx === 1'b1) idle_run++;
      else begin
        last_gap = idle_run;
        idle_run = 0;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_frame: got start bit expected idle line");
          for (int g = 0; g < 5000 && tx !== 1'b1 && !rst; g++) @(negedge clk);
        end else begin
          cur    = exp_q.pop_front();
          period = model_div + 1;
          bits   = '1;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = cur[i];
`ifdef UART_TX_PARITY_EN
          bits[9] = ^cur;
`endif
          aborted = 1'b0;
          for (int b = 0; b < NBITS && !aborted; b++) begin
            bad = 1'b0;
            got = bits[b];
            for (int s = 0; s < period; s++) begin
              if (!(b == 0 && s == 0)) @(negedge clk);
              if (rst) begin
                aborted = 1'b1;
                break;
              end
              if (tx !== bits[b]) begin
                bad = 1'b1;
                got = tx;
              end
            end
            if (!aborted) begin
              compared++;
              if (bad) begin
                mismatched++;
                $display("FAIL frame_bit byte=0x%0h bit=%0d: got %b expected %b", cur, b, got, bits[b]);
              end
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    int k, d, cnt;
    bit saw_busy, irq_in_frame;
    int busy_cnt;
    logic e19, e20, cnt0_ok;
    logic [4:0] cnt0;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(IRQ), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_read(1, rd); check("rst_status", rd, 32'h1);
    bus_read(2, rd); check("rst_div", rd, 32'd433);
    bus_read(3, rd); check("rst_ctrl", rd, 32'd0);
    bus_read(0, rd); check("data_read_zero", rd, 32'd0);

    // 0x55 at DIV=3 with write-to-start latency
    set_div(3);
    bus_write(3, 32'h1);
    exp_q.push_back(8'h55);
    bus_write(0, 32'h55);
    check("lat_before", 32'(tx), 32'd1);
    @(negedge clk);
    check("lat_fall", 32'(tx), 32'd0);
    bus_read(1, st);
    check("busy_in_frame", 32'(st[3]), 32'd1);
    wait_idle("f55", 300);

    // Fill with EN=0, overflow, OVF clear rules, rejected push on the pop edge
    bus_write(3, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < DEPTH) exp_q.push_back(b);
      bus_write(0, 32'(b));
    end
    bus_read(1, st);
    check("full_count", 32'(st[9:5]), 32'(DEPTH));
    check("full_flag", 32'(st[1]), 32'd1);
    check("full_ovf", 32'(st[4]), 32'd1);
    check("full_empty", 32'(st[0]), 32'd0);
    bus_write(1, 32'hFFFF_FFEF);
    bus_read(1, st);
    check("ovf_kept", 32'(st[4]), 32'd1);
    check("ro_count", 32'(st[9:5]), 32'(DEPTH));
    bus_write(1, 32'h10);
    bus_read(1, st);
    check("ovf_clear", 32'(st[4]), 32'd0);
    set_div(0);
    bus_write(3, 32'h1);
    bus_write(0, 32'hAA);
    bus_read(1, st);
    check("full_pop_push_count", 32'(st[9:5]), 32'(DEPTH - 1));
    check("full_pop_push_ovf", 32'(st[4]), 32'd1);
    wait_idle("fill", 1000);
    bus_write(1, 32'h10);

    // Back-to-back frames at DIV=1
    set_div(1);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    bus_write(0, 32'h01);
    bus_write(0, 32'h80);
    busy_cnt = 0; e19 = 1'bx; e20 = 1'bx; cnt0 = 'x; cnt0_ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bus_read(1, st);
      if (i == 0) begin cnt0 = st[9:5]; cnt0_ok = 1'b1; end
      if (i == 19) e19 = st[0];
      if (i == 20) e20 = st[0];
      if (!st[3]) break;
      busy_cnt++;
    end
    check("pushpop_count", 32'(cnt0), 32'd1);
    check("b2b_busy_run", 32'(busy_cnt), 32'd40);
    check("b2b_empty_before_pop2", 32'(e19), 32'd0);
    check("b2b_empty_after_pop2", 32'(e20), 32'd1);
    check("b2b_gap", 32'(last_gap), 32'd0);
    wait_idle("b2b", 300);

    // IRQ behaviour at DIV=0
    set_div(0);
    bus_write(3, 32'h3);
    bus_read(1, st);
    check("irq_idle", 32'(IRQ), 32'd1);
    exp_q.push_back(8'hC3);
    bus_write(0, 32'hC3);
    saw_busy = 1'b0; irq_in_frame = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus_read(1, st);
      if (st[3]) begin
        saw_busy = 1'b1;
        if (st[2]) irq_in_frame = 1'b1;
      end else if (saw_busy) break;
    end
    check("irq_saw_frame", 32'(saw_busy), 32'd1);
    check("irq_low_in_frame", 32'(irq_in_frame), 32'd0);
    check("irq_at_idle_entry", 32'(st[2]), 32'd0);
    check("irq_after_idle", 32'(IRQ), 32'd1);
    wait_idle("irq", 100);

    // Mid-frame DIV change affects the following frame only
    bus_write(3, 32'h1);
    set_div(3);
    b = 8'($urandom_range(0, 255));
    exp_q.push_back(b);
    exp_q.push_back(~b);
    bus_write(0, 32'(b));
    bus_write(0, 32'(~b));
    bus_write(2, 32'd7);
    model_div = 7;
    bus_read(2, rd);
    check("div_readback", rd, 32'd7);
    wait_idle("divchg", 500);

    // Randomised fills with model-predicted COUNT/FULL/OVF
    for (int it = 0; it < 6; it++) begin
      bus_write(3, 32'h0);
      bus_write(1, 32'h10);
      k = $urandom_range(1, DEPTH + 3);
      d = $urandom_range(0, 4);
      set_div(d);
      cnt = 0;
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom_range(0, 255));
        if (cnt < DEPTH) begin
          exp_q.push_back(b);
          cnt++;
        end
        bus_write(0, 32'(b));
      end
      bus_read(1, st);
      check("rnd_count", 32'(st[9:5]), 32'(cnt));
      check("rnd_full", 32'(st[1]), 32'(cnt == DEPTH));
      check("rnd_ovf", 32'(st[4]), 32'(k > DEPTH));
      bus_write(3, 32'h1);
      wait_idle("rnd", 1000);
    end

    // Reset in the middle of data bit 3 with bytes still queued
    bus_write(3, 32'h0);
    set_div(3);
    exp_q.push_back(8'hF0);
    bus_write(0, 32'hF0);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      bus_write(0, 32'(b));
    end
    bus_write(3, 32'h1);
    repeat (18) @(negedge clk);
    check("pre_rst_tx", 32'(tx), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx), 32'd1);
    check("rst_async_irq", 32'(IRQ), 32'd0);
    exp_q.delete();
    model_div = 433;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    bus_read(1, rd); check("post_rst_status", rd, 32'h1);
    bus_read(2, rd); check("post_rst_div", rd, 32'd433);
    bus_read(3, rd); check("post_rst_ctrl", rd, 32'd0);
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_irq", 32'(IRQ), 32'd0);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set transmit FIFO entries (power of two, 2..16).
REQ-002 Parameter DEFAULT_DIV, default 16'd433, SHALL set the divisor reset value.
REQ-003 clk  input  1  single system clock, rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 Addr  input  [31:2]  word address; only Addr[3:2] decoded (0 DATA, 1 STATUS, 2 DIV, 3 CTRL).
REQ-006 WE  input  1  write strobe, sampled at rising clk.
REQ-007 Din  input  32  write data.
REQ-008 Dout  output  32  combinational read data for Addr[3:2].
REQ-009 IRQ  output  1  registered level interrupt to the south bridge.
REQ-010 tx  output  1  registered serial line, idle high.

Function
REQ-011 DATA write SHALL push Din[7:0] when the FIFO is not full; reading DATA SHALL return 0.
REQ-012 DATA write while full SHALL be dropped and set sticky STATUS.OVF.
REQ-013 STATUS read SHALL return {22'b0, COUNT[4:0] at [9:5], OVF[4], BUSY[3], IRQ[2], FULL[1], EMPTY[0]}.
REQ-014 STATUS write with Din[4]=1 SHALL clear OVF; other bits read-only.
REQ-015 DIV (Din[15:0]) SHALL set the bit period to DIV+1 clk cycles; DIV read returns {16'b0, DIV}.
REQ-016 DIV SHALL be latched into the FSM only at frame start; writes mid-frame affect the next frame only.
REQ-017 CTRL bit0 EN, bit1 IE; CTRL read returns {30'b0, IE, EN}.
REQ-018 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-019 IDLE->START when EN=1 and FIFO non-empty; pop occurs on that same edge; tx=0 from that edge.
REQ-020 START->DATA after one bit period; DATA sends bits LSB first, 8 bit periods.
REQ-021 DATA->STOP (or PARITY) after bit 7; STOP drives tx=1 for one bit period, then IDLE.
REQ-022 STOP->START directly (no idle cycle) when EN=1 and FIFO non-empty at STOP end.
REQ-023 EN cleared mid-frame SHALL complete the current frame, then hold IDLE; FIFO contents retained.
REQ-024 Latency: DATA write in cycle c, FIFO empty, FSM IDLE, EN=1 -> tx falls at second rising edge after cycle c.
REQ-025 Simultaneous push and pop: both SHALL occur; COUNT unchanged; push into full FIFO rejected even if pop same edge.
REQ-026 BUSY SHALL be 1 in any state other than IDLE.
REQ-027 IRQ SHALL be registered IE & EMPTY & ~BUSY, updated every edge.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; COUNT ranges 0..DEPTH.

Reset
REQ-029 On rst: FSM IDLE, tx=1, IRQ=0, FIFO empty (COUNT=0), OVF=0, DIV=DEFAULT_DIV, EN=0, IE=0.
REQ-030 Reset asserted mid-frame SHALL force tx=1 immediately (asynchronously) and discard the frame and FIFO.

Configuration
REQ-031 Macro UART_TX_PARITY_EN defined: PARITY state inserted after DATA, sends even parity (XOR of 8 data bits) for one bit period; frame 11 bits.
REQ-032 Macro undefined: no PARITY state or logic; frame 10 bits (start, 8 data, stop).

Verification
REQ-033 Reset, DIV=3, EN=1, write DATA=0x55 -> tx: 0 for 4 cycles, 1,0,1,0,1,0,1,0 each 4 cycles, 1 for 4 cycles; frame 40 cycles (44 with parity bit 0).
REQ-034 EN=0, write 9 bytes with DEPTH=8 -> STATUS.COUNT=8, FULL=1, OVF=1; write STATUS Din=0x10 -> OVF=0.
REQ-035 DIV=1, EN=1, write 0x01 then 0x80 back-to-back -> two frames with no idle cycle between; BUSY=1 throughout; EMPTY=1 after second pop.
REQ-036 IE=1, EN=1, DIV=0, one byte -> IRQ=0 during frame, IRQ=1 one edge after FSM returns to IDLE.
REQ-037 Write DIV=7 during a DIV=3 frame -> current frame bits remain 4 cycles; next frame bits 8 cycles.
REQ-038 Assert rst at bit 3 of a frame with 3 bytes queued -> tx=1 immediately, COUNT=0, IRQ=0, DIV=433 after release.
